// File: rtl/redmule_pkg.sv
// Shared RedMulE types and sizes used by the Z store buffer and ctrl.
// Optional build macro REDMULE_ZBUF_STRB_EN is consumed by the buffer.
package redmule_pkg;

   localparam int unsigned ZBUF_HEIGHT = 4;
   localparam int unsigned ZBUF_WIDTH  = 8;
   localparam int unsigned ZBUF_DATAW  = 16;
   localparam int unsigned ZBUF_ELEMS  = ZBUF_WIDTH * ZBUF_HEIGHT;

   typedef struct packed {
      logic full;
      logic empty;
   } z_buffer_flgs_t;

   typedef enum logic [1:0] {
      ZBUF_FILL,
      ZBUF_FULL,
      ZBUF_DRAIN
   } zbuf_state_e;

endpackage

// File: rtl/redmule_z_store_buffer_if.sv
// Row stream from the Z buffer to the Z streamer (valid/ready).
// Strobe lane exists only when REDMULE_ZBUF_STRB_EN is defined.
interface redmule_z_store_buffer_if #(
   parameter int unsigned Width = 8,
   parameter int unsigned DataW = 16
);

   logic                     z_valid;
   logic                     z_ready;
   logic [Width*DataW-1:0]   z_data;
`ifdef REDMULE_ZBUF_STRB_EN
   logic [Width*DataW/8-1:0] z_strb;

   modport master (
      output z_valid,
      output z_data,
      output z_strb,
      input  z_ready
   );

   modport slave (
      input  z_valid,
      input  z_data,
      input  z_strb,
      output z_ready
   );
`else
   modport master (
      output z_valid,
      output z_data,
      input  z_ready
   );

   modport slave (
      input  z_valid,
      input  z_data,
      output z_ready
   );
`endif

endinterface

// File: rtl/redmule_z_transpose_mem.sv
// Height x Width element array: written one column at a time,
// read one row at a time, which turns engine columns into memory rows.
module redmule_z_transpose_mem #(
   parameter int unsigned Height = 4,
   parameter int unsigned Width  = 8,
   parameter int unsigned DataW  = 16
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic                       we,
   input  logic [$clog2(Width)-1:0]   wr_col,
   input  logic [Height*DataW-1:0]    wr_data,
   input  logic [$clog2(Height)-1:0]  rd_row,
   output logic [Width*DataW-1:0]     rd_data
);

   logic [DataW-1:0] mem [Height][Width];

   // Column write: element r of the engine vector lands in row r.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int r = 0; r < int'(Height); r++) begin
            mem[r][wr_col] <= wr_data[r*DataW +: DataW];
         end
      end
   end

   // Row read: element c of the output row comes from column c.
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < int'(Width); c++) begin
         rd_data[c*DataW +: DataW] = mem[rd_row][c];
      end
   end

endmodule

// File: rtl/redmule_z_store_buffer.sv
// Z tile buffer: collects engine columns, drains row-major rows.
// REDMULE_ZBUF_STRB_EN adds byte strobes instead of zeroing masked columns.
module redmule_z_store_buffer
   import redmule_pkg::*;
#(
   parameter int unsigned Height = ZBUF_HEIGHT,
   parameter int unsigned Width  = ZBUF_WIDTH,
   parameter int unsigned DataW  = ZBUF_DATAW
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       clk_en_i,
   input  logic                       fill_i,
   input  logic [Height*DataW-1:0]    z_i,
   input  logic                       store_i,
   input  logic [$clog2(Width):0]     cols_i,
   input  logic [$clog2(Height):0]    rows_i,
   redmule_z_store_buffer_if.master   z,
   output z_buffer_flgs_t             flgs_o,
   output logic                       ovf_o
);

   localparam int unsigned CW = $clog2(Width);
   localparam int unsigned RW = $clog2(Height);
   localparam logic [CW:0] ColMax = (CW+1)'(Width);
   localparam logic [RW:0] RowMax = (RW+1)'(Height);

   zbuf_state_e     state;
   logic [CW-1:0]   col_cnt;
   logic [RW-1:0]   row_cnt;
   logic [CW:0]     cols_q;
   logic [RW:0]     rows_q;
   logic            full_q;
   logic            valid_q;
   logic            ovf_q;

   logic [CW:0]     cols_eff;
   logic [RW:0]     rows_eff;
   logic [CW:0]     cols_cur;
   logic            last_col;
   logic            last_row;
   logic            wr;
   logic            hs;
   logic [Width*DataW-1:0] rd_data;

   assign cols_eff = (cols_i == '0 || cols_i > ColMax) ? ColMax : cols_i;
   assign rows_eff = (rows_i == '0 || rows_i > RowMax) ? RowMax : rows_i;

   // Tile size tracks the inputs until the first column is written.
   assign cols_cur = (col_cnt == '0) ? cols_eff : cols_q;
   assign last_col = ({1'b0, col_cnt} == cols_cur - 1'b1);
   assign last_row = ({1'b0, row_cnt} == rows_q - 1'b1);

   assign wr = (state == ZBUF_FILL) && fill_i && clk_en_i && !clear_i;
   assign hs = valid_q && z.z_ready;

   assign z.z_valid    = valid_q;
   assign flgs_o.full  = full_q;
   assign flgs_o.empty = hs && last_row && !clear_i;
   assign ovf_o        = ovf_q;

   redmule_z_transpose_mem #(
      .Height (Height),
      .Width  (Width),
      .DataW  (DataW)
   ) i_mem (
      .clk     (clk_i),
      .en      (clk_en_i),
      .we      (wr),
      .wr_col  (col_cnt),
      .wr_data (z_i),
      .rd_row  (row_cnt),
      .rd_data (rd_data)
   );

`ifdef REDMULE_ZBUF_STRB_EN
   // Masked columns keep stale data; strobes mark the valid bytes.
   always_comb begin
      z.z_data = rd_data;
      z.z_strb = '0;
      for (int c = 0; c < int'(Width); c++) begin
         if ((CW+1)'(c) < cols_q) begin
            z.z_strb[c*DataW/8 +: DataW/8] = '1;
         end
      end
   end
`else
   // Columns beyond the tile width are forced to zero.
   always_comb begin
      z.z_data = '0;
      for (int c = 0; c < int'(Width); c++) begin
         if ((CW+1)'(c) < cols_q) begin
            z.z_data[c*DataW +: DataW] = rd_data[c*DataW +: DataW];
         end
      end
   end
`endif

   // Fill / full / drain sequencing with registered flags and valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= ZBUF_FILL;
         col_cnt <= '0;
         row_cnt <= '0;
         cols_q  <= ColMax;
         rows_q  <= RowMax;
         full_q  <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (clear_i) begin
         state   <= ZBUF_FILL;
         col_cnt <= '0;
         row_cnt <= '0;
         full_q  <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (fill_i && clk_en_i && state != ZBUF_FILL) begin
            ovf_q <= 1'b1;
         end
         unique case (state)
            ZBUF_FILL: begin
               if (col_cnt == '0) begin
                  cols_q <= cols_eff;
                  rows_q <= rows_eff;
               end
               if (fill_i && clk_en_i) begin
                  if (last_col) begin
                     col_cnt <= '0;
                     full_q  <= 1'b1;
                     state   <= ZBUF_FULL;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
               end
            end
            ZBUF_FULL: begin
               if (store_i) begin
                  valid_q <= 1'b1;
                  state   <= ZBUF_DRAIN;
               end
            end
            ZBUF_DRAIN: begin
               if (hs) begin
                  full_q <= 1'b0;
                  if (last_row) begin
                     row_cnt <= '0;
                     valid_q <= 1'b0;
                     state   <= ZBUF_FILL;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end
            end
            default: state <= ZBUF_FILL;
         endcase
      end
   end

endmodule
